tri_port_ram_ctrl: RTL and testbench

TRI_PORT_RAM_CTRL -- requirements
Module: tri_port_ram_ctrl

---
 rtl/tri_port_ram_ctrl_if.sv | 28 ++
 rtl/tri_port_ram_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_tri_port_ram_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tri_port_ram_ctrl_if.sv
// Client-side bus of one tri_port_ram_ctrl port: a request/grant handshake
// carrying a word access, plus the read-data return path.
interface tri_port_ram_ctrl_if #(
  parameter int no_addr_lines = 5,
  parameter int wordsize      = 16
);

  logic                     req;
  logic                     we;
  logic [no_addr_lines-1:0] addr;
  logic [wordsize-1:0]      wdata;
  logic                     gnt;
  logic [wordsize-1:0]      rdata;
  logic                     rvalid;

  // Client side: issues requests, sees grants and read data.
  modport master (
    output req, we, addr, wdata,
    input  gnt, rdata, rvalid
  );

  // Controller side.
  modport slave (
    input  req, we, addr, wdata,
    output gnt, rdata, rvalid
  );

endinterface

// File: rtl/tri_port_ram_ctrl.sv
// Three-port (L, R, M) access controller in front of a tri-port RAM cell matrix.
// Requests to the same word where at least one side writes are serialised by a
// rotating priority pointer; everything else is granted in the same cycle.
// Accepted requests drive the RAM one cycle later; read data returns one cycle
// after that as a single-cycle rvalid pulse.
// Optional: define RAM_CTRL_COLLISION_CNT_EN to add an 8-bit saturating count
// of cycles that contained at least one conflict.
module tri_port_ram_ctrl #(
  parameter int N             = 32,
  parameter int no_addr_lines = 5,
  parameter int wordsize      = 16
) (
  input  logic                     clk,
  input  logic                     rst,

  tri_port_ram_ctrl_if.slave       L,
  tri_port_ram_ctrl_if.slave       R,
  tri_port_ram_ctrl_if.slave       M,

  output logic [no_addr_lines-1:0] L_address,
  output logic [no_addr_lines-1:0] R_address,
  output logic [no_addr_lines-1:0] M_address,
  output logic                     Left_Write,
  output logic                     Right_Write,
  output logic                     Middle_Write,
  output logic [wordsize-1:0]      L_Data_Bit_Line,
  output logic [wordsize-1:0]      R_Data_Bit_Line,
  output logic [wordsize-1:0]      M_Data_Bit_Line,
  input  logic [wordsize-1:0]      L_Data_Bit_Line_read,
  input  logic [wordsize-1:0]      R_Data_Bit_Line_read,
`ifdef RAM_CTRL_COLLISION_CNT_EN
  input  logic [wordsize-1:0]      M_Data_Bit_Line_read,
  output logic [7:0]               collision_cnt
`else
  input  logic [wordsize-1:0]      M_Data_Bit_Line_read
`endif
);

  // Port indices used by the internal arrays.
  localparam int PL = 0;
  localparam int PR = 1;
  localparam int PM = 2;

  // The matrix must fit inside the address space.
  if (N > (1 << no_addr_lines)) begin : g_depth_check
    $error("tri_port_ram_ctrl: N exceeds the range of no_addr_lines");
  end

  typedef enum logic [1:0] {
    PRI_L,
    PRI_R,
    PRI_M
  } pri_e;

  pri_e state_q, state_d;

  // Flattened view of the three client buses.
  logic [2:0]               req;
  logic [2:0]               we;
  logic [no_addr_lines-1:0] addr    [3];
  logic [wordsize-1:0]      wdata   [3];
  logic [wordsize-1:0]      rd_in   [3];

  // Arbitration results.
  logic                     conf_lr, conf_lm, conf_rm;
  logic [2:0]               in_conf;
  logic                     any_conf;
  logic [2:0]               win;
  logic [2:0]               gnt;

  // Pipeline state: stage 1 drives the RAM, stage 2 returns read data.
  logic [2:0]               write_q;
  logic [2:0]               rd_pend_q;
  logic [no_addr_lines-1:0] addr_q  [3];
  logic [wordsize-1:0]      wdata_q [3];
  logic [2:0]               rvalid_q;
  logic [wordsize-1:0]      rdata_q [3];

  // Gather client inputs; requests are masked while reset is held.
  always_comb begin
    req       = {M.req, R.req, L.req} & {3{~rst}};
    we        = {M.we, R.we, L.we};
    addr[PL]  = L.addr;
    addr[PR]  = R.addr;
    addr[PM]  = M.addr;
    wdata[PL] = L.wdata;
    wdata[PR] = R.wdata;
    wdata[PM] = M.wdata;
    rd_in[PL] = L_Data_Bit_Line_read;
    rd_in[PR] = R_Data_Bit_Line_read;
    rd_in[PM] = M_Data_Bit_Line_read;
  end

  // Pairwise conflict: both requesting, same word, at least one writer.
  always_comb begin
    conf_lr      = req[PL] & req[PR] & (addr[PL] == addr[PR]) & (we[PL] | we[PR]);
    conf_lm      = req[PL] & req[PM] & (addr[PL] == addr[PM]) & (we[PL] | we[PM]);
    conf_rm      = req[PR] & req[PM] & (addr[PR] == addr[PM]) & (we[PR] | we[PM]);
    in_conf[PL]  = conf_lr | conf_lm;
    in_conf[PR]  = conf_lr | conf_rm;
    in_conf[PM]  = conf_lm | conf_rm;
    any_conf     = |in_conf;
  end

  // Priority pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PRI_L;
    end else begin
      state_q <= state_d;
    end
  end

  // Pick the conflict winner from the pointer, form grants, advance the pointer.
  // With three ports all conflicting ports share one address, so there is at
  // most one conflict group per cycle.
  always_comb begin
    win     = 3'b000;
    state_d = state_q;
    unique case (state_q)
      PRI_L: begin
        if      (in_conf[PL]) win = 3'b001;
        else if (in_conf[PR]) win = 3'b010;
        else if (in_conf[PM]) win = 3'b100;
      end
      PRI_R: begin
        if      (in_conf[PR]) win = 3'b010;
        else if (in_conf[PM]) win = 3'b100;
        else if (in_conf[PL]) win = 3'b001;
      end
      PRI_M: begin
        if      (in_conf[PM]) win = 3'b100;
        else if (in_conf[PL]) win = 3'b001;
        else if (in_conf[PR]) win = 3'b010;
      end
      default: begin
        win     = 3'b000;
        state_d = PRI_L;
      end
    endcase

    gnt = req & (~in_conf | win);

    if (any_conf) begin
      unique case (1'b1)
        win[PL]: state_d = PRI_R;
        win[PR]: state_d = PRI_M;
        win[PM]: state_d = PRI_L;
        default: state_d = state_q;
      endcase
    end
  end

  // Register accepted requests; address and data lines only move on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q   <= 3'b000;
      rd_pend_q <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
      end
    end else begin
      write_q   <= gnt & we;
      rd_pend_q <= gnt & ~we;
      for (int i = 0; i < 3; i++) begin
        if (gnt[i]) begin
          addr_q[i]  <= addr[i];
          wdata_q[i] <= wdata[i];
        end
      end
    end
  end

  // Capture read data at the end of the RAM cycle; rdata holds until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        rdata_q[i] <= '0;
      end
    end else begin
      rvalid_q <= rd_pend_q;
      for (int i = 0; i < 3; i++) begin
        if (rd_pend_q[i]) begin
          rdata_q[i] <= rd_in[i];
        end
      end
    end
  end

`ifdef RAM_CTRL_COLLISION_CNT_EN
  // Saturating count of cycles that contained a conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      collision_cnt <= 8'd0;
    end else if (any_conf && (collision_cnt != 8'hFF)) begin
      collision_cnt <= collision_cnt + 8'd1;
    end
  end
`endif

  assign L.gnt    = gnt[PL];
  assign R.gnt    = gnt[PR];
  assign M.gnt    = gnt[PM];
  assign L.rvalid = rvalid_q[PL];
  assign R.rvalid = rvalid_q[PR];
  assign M.rvalid = rvalid_q[PM];
  assign L.rdata  = rdata_q[PL];
  assign R.rdata  = rdata_q[PR];
  assign M.rdata  = rdata_q[PM];

  assign L_address       = addr_q[PL];
  assign R_address       = addr_q[PR];
  assign M_address       = addr_q[PM];
  assign Left_Write      = write_q[PL];
  assign Right_Write     = write_q[PR];
  assign Middle_Write    = write_q[PM];
  assign L_Data_Bit_Line = wdata_q[PL];
  assign R_Data_Bit_Line = wdata_q[PR];
  assign M_Data_Bit_Line = wdata_q[PM];

endmodule

// File: tb/tb_tri_port_ram_ctrl.sv
// Bench for tri_port_ram_ctrl: directed scenarios followed by random traffic,
// checked against a transaction-level model (word array, rotating pointer index).
module tb_tri_port_ram_ctrl;

  localparam int N  = 32;
  localparam int AW = 5;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tri_port_ram_ctrl_if #(.no_addr_lines(AW), .wordsize(DW)) l_bus ();
  tri_port_ram_ctrl_if #(.no_addr_lines(AW), .wordsize(DW)) r_bus ();
  tri_port_ram_ctrl_if #(.no_addr_lines(AW), .wordsize(DW)) m_bus ();

  logic [AW-1:0] L_address, R_address, M_address;
  logic          Left_Write, Right_Write, Middle_Write;
  logic [DW-1:0] L_Data_Bit_Line, R_Data_Bit_Line, M_Data_Bit_Line;
  logic [DW-1:0] L_rd, R_rd, M_rd;
`ifdef RAM_CTRL_COLLISION_CNT_EN
  logic [7:0]    collision_cnt;
`endif

  // RAM cell matrix: synchronous write, combinational read.
  logic [DW-1:0] mem [N];
  always @(posedge clk) begin
    if (Left_Write)   mem[L_address] <= L_Data_Bit_Line;
    if (Right_Write)  mem[R_address] <= R_Data_Bit_Line;
    if (Middle_Write) mem[M_address] <= M_Data_Bit_Line;
  end
  assign L_rd = mem[L_address];
  assign R_rd = mem[R_address];
  assign M_rd = mem[M_address];

  tri_port_ram_ctrl #(.N(N), .no_addr_lines(AW), .wordsize(DW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .L                    (l_bus),
    .R                    (r_bus),
    .M                    (m_bus),
    .L_address            (L_address),
    .R_address            (R_address),
    .M_address            (M_address),
    .Left_Write           (Left_Write),
    .Right_Write          (Right_Write),
    .Middle_Write         (Middle_Write),
    .L_Data_Bit_Line      (L_Data_Bit_Line),
    .R_Data_Bit_Line      (R_Data_Bit_Line),
    .M_Data_Bit_Line      (M_Data_Bit_Line),
    .L_Data_Bit_Line_read (L_rd),
    .R_Data_Bit_Line_read (R_rd),
`ifdef RAM_CTRL_COLLISION_CNT_EN
    .M_Data_Bit_Line_read (M_rd),
    .collision_cnt        (collision_cnt)
`else
    .M_Data_Bit_Line_read (M_rd)
`endif
  );

  // Stimulus, indexed 0=L, 1=R, 2=M.
  logic          s_req   [3];
  logic          s_we    [3];
  logic [AW-1:0] s_addr  [3];
  logic [DW-1:0] s_wdata [3];

  assign l_bus.req = s_req[0];  assign l_bus.we = s_we[0];
  assign r_bus.req = s_req[1];  assign r_bus.we = s_we[1];
  assign m_bus.req = s_req[2];  assign m_bus.we = s_we[2];
  assign l_bus.addr = s_addr[0];  assign l_bus.wdata = s_wdata[0];
  assign r_bus.addr = s_addr[1];  assign r_bus.wdata = s_wdata[1];
  assign m_bus.addr = s_addr[2];  assign m_bus.wdata = s_wdata[2];

  logic          d_gnt [3], d_rv [3], d_wr [3];
  logic [DW-1:0] d_rd  [3], d_data [3];
  logic [AW-1:0] d_addr [3];
  always_comb begin
    d_gnt[0] = l_bus.gnt;     d_gnt[1] = r_bus.gnt;     d_gnt[2] = m_bus.gnt;
    d_rv[0]  = l_bus.rvalid;  d_rv[1]  = r_bus.rvalid;  d_rv[2]  = m_bus.rvalid;
    d_rd[0]  = l_bus.rdata;   d_rd[1]  = r_bus.rdata;   d_rd[2]  = m_bus.rdata;
    d_wr[0]  = Left_Write;    d_wr[1]  = Right_Write;   d_wr[2]  = Middle_Write;
    d_addr[0] = L_address;    d_addr[1] = R_address;    d_addr[2] = M_address;
    d_data[0] = L_Data_Bit_Line; d_data[1] = R_Data_Bit_Line; d_data[2] = M_Data_Bit_Line;
  end

  // Reference model state.
  int            tests = 0;
  int            fails = 0;
  int            ptr;                 // 0=L, 1=R, 2=M: port searched first on conflict
  logic [DW-1:0] mmem [N];
  bit            granted [3];
  bit            exp_wr [3];
  logic [AW-1:0] exp_addr [3];
  logic [DW-1:0] exp_data [3];
  bit            pend_v [3];
  logic [DW-1:0] pend_d [3];
  bit            exp_rv [3];
  logic [DW-1:0] exp_rd [3];
  int            exp_cnt;

  task automatic chk(input string tag, input int p, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, p, obs, exp);
    end
  endtask

  task automatic check_outputs();
    for (int p = 0; p < 3; p++) begin
      chk("write_line", p, 32'(d_wr[p]), 32'(exp_wr[p]));
      chk("address", p, 32'(d_addr[p]), 32'(exp_addr[p]));
      chk("data_line", p, 32'(d_data[p]), 32'(exp_data[p]));
      chk("rvalid", p, 32'(d_rv[p]), 32'(exp_rv[p]));
      chk("rdata", p, 32'(d_rd[p]), 32'(exp_rd[p]));
    end
`ifdef RAM_CTRL_COLLISION_CNT_EN
    chk("collision_cnt", 0, 32'(collision_cnt), 32'(exp_cnt));
`endif
  endtask

  // One clock cycle: check grants against the model, clock, then check outputs.
  // Called and returns in the low phase after a falling edge.
  task automatic step();
    bit conf [3];
    bit acc  [3];
    int w;
    #1;
    for (int p = 0; p < 3; p++) begin
      conf[p] = 1'b0;
      for (int q = 0; q < 3; q++) begin
        if (q != p && !rst && s_req[p] && s_req[q] && s_addr[p] == s_addr[q] &&
            (s_we[p] || s_we[q])) conf[p] = 1'b1;
      end
    end
    w = -1;
    for (int k = 0; k < 3; k++) begin
      if (w < 0 && conf[(ptr + k) % 3]) w = (ptr + k) % 3;
    end
    for (int p = 0; p < 3; p++) begin
      acc[p] = !rst && s_req[p] && (!conf[p] || p == w);
      granted[p] = acc[p];
      chk("gnt", p, 32'(d_gnt[p]), 32'(acc[p]));
    end
    @(posedge clk);
    // Reads observe every write accepted in an earlier cycle.
    for (int p = 0; p < 3; p++) begin
      exp_rv[p] = pend_v[p];
      if (pend_v[p]) exp_rd[p] = pend_d[p];
      pend_v[p] = acc[p] && !s_we[p];
      if (pend_v[p]) pend_d[p] = mmem[s_addr[p]];
    end
    for (int p = 0; p < 3; p++) begin
      if (acc[p] && s_we[p]) mmem[s_addr[p]] = s_wdata[p];
      exp_wr[p] = acc[p] && s_we[p];
      if (acc[p]) begin
        exp_addr[p] = s_addr[p];
        exp_data[p] = s_wdata[p];
      end
    end
    if (w >= 0) begin
      ptr = (w + 1) % 3;
      if (exp_cnt < 255) exp_cnt++;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_port(input int p, input bit req, input bit we, input int a,
                          input logic [DW-1:0] d);
    s_req[p]   = req;
    s_we[p]    = we;
    s_addr[p]  = AW'(a);
    s_wdata[p] = d;
  endtask

  task automatic idle();
    for (int p = 0; p < 3; p++) s_req[p] = 1'b0;
  endtask

  task automatic apply_reset();
    for (int p = 0; p < 3; p++) set_port(p, 1'b1, 1'b0, p, '0);
    rst = 1'b1;
    #1;
    ptr = 0;
    exp_cnt = 0;
    for (int p = 0; p < 3; p++) begin
      exp_wr[p] = 1'b0;  exp_addr[p] = '0;  exp_data[p] = '0;
      pend_v[p] = 1'b0;  exp_rv[p] = 1'b0;  exp_rd[p] = '0;
      chk("gnt_in_reset", p, 32'(d_gnt[p]), 32'd0);
    end
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    for (int p = 0; p < 3; p++) chk("gnt_in_reset", p, 32'(d_gnt[p]), 32'd0);
    rst = 1'b0;
    idle();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      mem[i]  = '0;
      mmem[i] = '0;
    end
    for (int p = 0; p < 3; p++) set_port(p, 1'b0, 1'b0, 0, '0);
    apply_reset();

    // Three writes to distinct words in one cycle.
    set_port(0, 1'b1, 1'b1, 0, 16'h0000);
    set_port(1, 1'b1, 1'b1, 1, 16'h000F);
    set_port(2, 1'b1, 1'b1, 2, 16'h00FF);
    step();
    chk("s1_write_all", 0, 32'({Left_Write, Right_Write, Middle_Write}), 32'h7);
    chk("s1_m_data", 2, 32'(M_Data_Bit_Line), 32'h00FF);

    // Three reads of the same word are all granted at once.
    for (int p = 0; p < 3; p++) set_port(p, 1'b1, 1'b0, 2, '0);
    step();
    idle();
    step();
    for (int p = 0; p < 3; p++) chk("s2_rdata", p, 32'(d_rd[p]), 32'h00FF);

    // L and M write the same word; pointer at L.
    set_port(0, 1'b1, 1'b1, 5, 16'h1111);
    set_port(2, 1'b1, 1'b1, 5, 16'h2222);
    #1;
    chk("s3_l_first", 0, 32'({l_bus.gnt, m_bus.gnt}), 32'h2);
    step();
    s_req[0] = 1'b0;
    step();
    idle();
    set_port(0, 1'b1, 1'b0, 5, '0);
    step();
    idle();
    step();
    chk("s3_rdata", 0, 32'(l_bus.rdata), 32'h2222);

    // Pointer is at R: an R-vs-L conflict moves it on to M.
    set_port(0, 1'b1, 1'b1, 9, 16'h0009);
    set_port(1, 1'b1, 1'b1, 9, 16'h0090);
    step();
    s_req[1] = 1'b0;
    step();
    idle();

    // R reads while M writes the same word; pointer at M.
    set_port(1, 1'b1, 1'b0, 7, '0);
    set_port(2, 1'b1, 1'b1, 7, 16'hABCD);
    #1;
    chk("s4_m_first", 0, 32'({r_bus.gnt, m_bus.gnt}), 32'h1);
    step();
    s_req[2] = 1'b0;
    step();
    idle();
    step();
    chk("s4_rdata", 1, 32'(r_bus.rdata), 32'hABCD);

    // Reset lands while a read is on the RAM bus.
    set_port(0, 1'b1, 1'b0, 2, '0);
    step();
    idle();
    apply_reset();
    step();
    step();
    set_port(0, 1'b1, 1'b1, 4, 16'h0044);
    set_port(1, 1'b1, 1'b1, 4, 16'h0444);
    #1;
    chk("s5_ptr_l", 0, 32'({l_bus.gnt, r_bus.gnt}), 32'h2);
    step();
    s_req[0] = 1'b0;
    step();
    idle();
    step();

`ifdef RAM_CTRL_COLLISION_CNT_EN
    // Persistent conflict: counter must saturate.
    apply_reset();
    set_port(0, 1'b1, 1'b1, 3, 16'h3333);
    set_port(1, 1'b1, 1'b1, 3, 16'h4444);
    for (int i = 0; i < 300; i++) step();
    chk("cnt_saturated", 0, 32'(collision_cnt), 32'd255);
    idle();
    step();
`endif

    // Random traffic over a few words so conflicts are frequent; losers hold.
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 3; p++) begin
        if (!(s_req[p] && !granted[p])) begin
          s_req[p]   = ($urandom_range(0, 9) < 7);
          s_we[p]    = 1'($urandom_range(0, 1));
          s_addr[p]  = AW'($urandom_range(0, 3));
          s_wdata[p] = DW'($urandom);
        end
      end
      step();
    end
    idle();
    step();
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
